ex_stage: RTL and testbench

- Execute stage of the 5-stage 16-bit pipeline; directly consumes the ID/EX pipeline latch outputs.
- Computes the ALU or address result and maintains the architectural flag register (Z, V, N).
- Registers its results into the EX/MEM boundary, one cycle after operands are presented.
- Honours the hazard unit's stall (en) and the branch unit's flush.

---
 rtl/ex_stage_if.sv | 44 ++++
 rtl/ex_stage.sv | 95 +++++++++
 tb/tb_ex_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operand/control inputs and EX/MEM registered outputs of the execute stage
//   master: drives ID/EX fields (en, flush, valid_in, alu_op, ALUSrc, Lower, Higher,
//           a_in, b_in, imm_in, wreg_in, reg_write_in, mem_read_in, mem_write_in)
//           and observes EX/MEM fields (alu_out, store_data, wreg_out, reg_write_out,
//           mem_read_out, mem_write_out, valid_out, flags)
//   slave:  the execute stage itself
interface ex_stage_if;
    logic        en;
    logic        flush;
    logic        valid_in;
    logic [3:0]  alu_op;
    logic        ALUSrc;
    logic        Lower;
    logic        Higher;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [15:0] imm_in;
    logic [3:0]  wreg_in;
    logic        reg_write_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [15:0] alu_out;
    logic [15:0] store_data;
    logic [3:0]  wreg_out;
    logic        reg_write_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic        valid_out;
    logic [2:0]  flags;

    modport master (
        output en, flush, valid_in, alu_op, ALUSrc, Lower, Higher, a_in, b_in, imm_in,
               wreg_in, reg_write_in, mem_read_in, mem_write_in,
        input  alu_out, store_data, wreg_out, reg_write_out, mem_read_out, mem_write_out,
               valid_out, flags
    );

    modport slave (
        input  en, flush, valid_in, alu_op, ALUSrc, Lower, Higher, a_in, b_in, imm_in,
               wreg_in, reg_write_in, mem_read_in, mem_write_in,
        output alu_out, store_data, wreg_out, reg_write_out, mem_read_out, mem_write_out,
               valid_out, flags
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: 16-bit pipeline execute stage with ALU, {Z,V,N} flag register and EX/MEM register
//   clk: rising-edge clock; rst: asynchronous active-high reset
//   bus: ex_stage_if.slave carrying ID/EX inputs and registered EX/MEM outputs
module ex_stage #(
    parameter int WIDTH = 16
) (
    input logic     clk,
    input logic     rst,
    ex_stage_if.slave bus
);
    logic [WIDTH-1:0] a, op2, res, sum_s, dif_s, red, psb, sll, sra, ror;
    logic [WIDTH:0]   sum, dif;
    logic [3:0]       sh;
    logic             sum_v, dif_v, upd_all, upd_z, do_flags;

    assign a   = bus.a_in;
    assign op2 = bus.ALUSrc ? bus.imm_in : bus.b_in;
    assign sh  = op2[3:0];

    // A 17-bit sign-extended sum exposes overflow as disagreement of the top two bits
    assign sum   = {a[15], a} + {op2[15], op2};
    assign dif   = {a[15], a} - {op2[15], op2};
    assign sum_v = sum[16] ^ sum[15];
    assign dif_v = dif[16] ^ dif[15];
    assign sum_s = sum_v ? (sum[16] ? 16'h8000 : 16'h7FFF) : sum[15:0];
    assign dif_s = dif_v ? (dif[16] ? 16'h8000 : 16'h7FFF) : dif[15:0];

    assign red = {{8{a[15]}}, a[15:8]} + {{8{a[7]}}, a[7:0]}
               + {{8{op2[15]}}, op2[15:8]} + {{8{op2[7]}}, op2[7:0]};

    for (genvar n = 0; n < 4; n++) begin : g_nib
        logic [4:0] s;
        assign s = {a[4*n+3], a[4*n +: 4]} + {op2[4*n+3], op2[4*n +: 4]};
        assign psb[4*n +: 4] = (s[4] ^ s[3]) ? (s[4] ? 4'h8 : 4'h7) : s[3:0];
    end

    assign sll = a << sh;
    assign sra = $signed(a) >>> sh;
    // sh=0 makes the left term shift by 16, i.e. zero, leaving a unchanged
    assign ror = (a >> sh) | (a << (5'd16 - {1'b0, sh}));

    always_comb begin
        res     = a;
        upd_all = 1'b0;
        upd_z   = 1'b0;
        case (bus.alu_op)
            4'b0000: begin res = sum_s; upd_all = 1'b1; end
            4'b0001: begin res = dif_s; upd_all = 1'b1; end
            4'b0010: begin res = a ^ op2; upd_z = 1'b1; end
            4'b0011: res = red;
            4'b0100: begin res = sll; upd_z = 1'b1; end
            4'b0101: begin res = sra; upd_z = 1'b1; end
            4'b0110: begin res = ror; upd_z = 1'b1; end
            4'b0111: res = psb;
            4'b1000, 4'b1001: res = a + bus.imm_in;
            default: res = a;
        endcase
        if (bus.Lower)
            res = {a[15:8], bus.imm_in[7:0]};
        else if (bus.Higher)
            res = {bus.imm_in[7:0], a[7:0]};
    end

    assign do_flags = bus.valid_in && !bus.Lower && !bus.Higher;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_out       <= '0;
            bus.store_data    <= '0;
            bus.wreg_out      <= '0;
            bus.reg_write_out <= 1'b0;
            bus.mem_read_out  <= 1'b0;
            bus.mem_write_out <= 1'b0;
            bus.valid_out     <= 1'b0;
            bus.flags         <= '0;
        end else if (bus.flush) begin
            bus.reg_write_out <= 1'b0;
            bus.mem_read_out  <= 1'b0;
            bus.mem_write_out <= 1'b0;
            bus.valid_out     <= 1'b0;
        end else if (bus.en) begin
            bus.alu_out       <= res;
            bus.store_data    <= bus.b_in;
            bus.wreg_out      <= bus.wreg_in;
            bus.reg_write_out <= bus.reg_write_in & bus.valid_in;
            bus.mem_read_out  <= bus.mem_read_in & bus.valid_in;
            bus.mem_write_out <= bus.mem_write_in & bus.valid_in;
            bus.valid_out     <= bus.valid_in;
            if (do_flags && upd_all)
                bus.flags <= {res == 16'h0, bus.alu_op[0] ? dif_v : sum_v, res[15]};
            else if (do_flags && upd_z)
                bus.flags <= {res == 16'h0, bus.flags[1:0]};
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total = 0;

    ex_stage_if bus ();
    ex_stage #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    task automatic op(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] imm, input logic src);
        bus.alu_op = code; bus.a_in = a; bus.b_in = b; bus.imm_in = imm; bus.ALUSrc = src;
        bus.Lower = 1'b0; bus.Higher = 1'b0; bus.valid_in = 1'b1; bus.en = 1'b1;
        bus.flush = 1'b0; bus.reg_write_in = 1'b1; bus.mem_read_in = 1'b0;
        bus.mem_write_in = 1'b0; bus.wreg_in = 4'h3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        op(4'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        tick();
        chk("rst_alu", bus.alu_out, 16'h0);
        chk("rst_flags", {13'h0, bus.flags}, 16'h0);
        chk("rst_valid", {15'h0, bus.valid_out}, 16'h0);
        rst = 1'b0;

        op(4'h0, 16'h7FFF, 16'h0001, 16'h0, 1'b0); tick();
        chk("add_sat", bus.alu_out, 16'h7FFF);
        chk("add_flags", {13'h0, bus.flags}, 16'h2);
        chk("add_valid", {15'h0, bus.valid_out}, 16'h1);
        chk("add_rw", {15'h0, bus.reg_write_out}, 16'h1);

        op(4'h1, 16'h8000, 16'h0001, 16'h0, 1'b0); tick();
        chk("sub_sat", bus.alu_out, 16'h8000);
        chk("sub_flags", {13'h0, bus.flags}, 16'h3);

        op(4'h7, 16'h7F18, 16'h1188, 16'h0, 1'b0); tick();
        chk("paddsb", bus.alu_out, 16'h7098);
        chk("paddsb_flags", {13'h0, bus.flags}, 16'h3);

        op(4'h2, 16'h1234, 16'h1234, 16'h0, 1'b0); tick();
        chk("xor", bus.alu_out, 16'h0);
        chk("xor_flags", {13'h0, bus.flags}, 16'h7);

        op(4'h0, 16'h12AB, 16'h0, 16'h00CD, 1'b1); bus.Higher = 1'b1; tick();
        chk("lhb", bus.alu_out, 16'hCDAB);
        chk("lhb_flags", {13'h0, bus.flags}, 16'h7);

        op(4'h0, 16'h12AB, 16'h0, 16'h00CD, 1'b1); bus.Higher = 1'b1; bus.Lower = 1'b1; tick();
        chk("llb_prio", bus.alu_out, 16'h12CD);

        op(4'h9, 16'h1000, 16'hBEEF, 16'hFFFE, 1'b1);
        bus.mem_write_in = 1'b1; bus.reg_write_in = 1'b0; tick();
        chk("sw_addr", bus.alu_out, 16'h0FFE);
        chk("sw_data", bus.store_data, 16'hBEEF);
        chk("sw_mw", {15'h0, bus.mem_write_out}, 16'h1);
        chk("sw_rw", {15'h0, bus.reg_write_out}, 16'h0);
        chk("sw_flags", {13'h0, bus.flags}, 16'h7);

        op(4'h5, 16'h8000, 16'h0004, 16'h0, 1'b0); tick();
        chk("sra", bus.alu_out, 16'hF800);
        chk("sra_flags", {13'h0, bus.flags}, 16'h3);

        op(4'h6, 16'h1234, 16'h0004, 16'h0, 1'b0); tick();
        chk("ror", bus.alu_out, 16'h4123);

        op(4'h3, 16'h7F80, 16'h0102, 16'h0, 1'b0); tick();
        chk("red", bus.alu_out, 16'h0002);

        op(4'h4, 16'h0001, 16'h0010, 16'h0, 1'b0); tick();
        chk("sll_zero", bus.alu_out, 16'h0001);

        op(4'h0, 16'h0005, 16'h1111, 16'hFFFB, 1'b1); tick();
        chk("add_imm", bus.alu_out, 16'h0);
        chk("add_imm_flags", {13'h0, bus.flags}, 16'h4);

        op(4'h8, 16'h0100, 16'h0, 16'h0004, 1'b1); bus.mem_read_in = 1'b1; tick();
        chk("lw_addr", bus.alu_out, 16'h0104);
        chk("lw_mr", {15'h0, bus.mem_read_out}, 16'h1);

        for (int i = 0; i < 3; i++) begin
            op(4'h1, 16'h8000 + 16'(i), 16'h0001, 16'h0, 1'b0); bus.en = 1'b0; tick();
            chk("stall_alu", bus.alu_out, 16'h0104);
            chk("stall_flags", {13'h0, bus.flags}, 16'h4);
            chk("stall_mr", {15'h0, bus.mem_read_out}, 16'h1);
        end

        bus.flush = 1'b1; tick();
        chk("flush_valid", {15'h0, bus.valid_out}, 16'h0);
        chk("flush_ctl", {13'h0, bus.reg_write_out, bus.mem_read_out, bus.mem_write_out}, 16'h0);
        chk("flush_alu", bus.alu_out, 16'h0104);
        chk("flush_flags", {13'h0, bus.flags}, 16'h4);

        op(4'h0, 16'h7FFF, 16'h0001, 16'h0, 1'b0); tick();
        chk("pre_rst_alu", bus.alu_out, 16'h7FFF);
        rst = 1'b1; #1;
        chk("async_rst_alu", bus.alu_out, 16'h0);
        chk("async_rst_flags", {13'h0, bus.flags}, 16'h0);
        chk("async_rst_valid", {15'h0, bus.valid_out}, 16'h0);
        tick();
        chk("rst_hold_alu", bus.alu_out, 16'h0);
        chk("rst_hold_valid", {15'h0, bus.valid_out}, 16'h0);
        rst = 1'b0;
        bus.valid_in = 1'b0; tick();
        chk("bubble_valid", {15'h0, bus.valid_out}, 16'h0);
        chk("bubble_rw", {15'h0, bus.reg_write_out}, 16'h0);
        chk("bubble_flags", {13'h0, bus.flags}, 16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
